// File: rtl/song_reader_if.sv
// Bundles the song ROM bus and the note_player hand-off seen by song_reader.
interface song_reader_if #(
    parameter int NOTE_IDX_W = 5,
    parameter int SONG_W     = 2
);
    logic [SONG_W+NOTE_IDX_W-1:0] rom_addr;
    logic [11:0]                  rom_dout;
    logic [5:0]                   note;
    logic [5:0]                   duration;
    logic                         new_note;
    logic                         song_done;
    logic                         note_done;

    modport master (
        output rom_addr,
        input  rom_dout,
        output note,
        output duration,
        output new_note,
        output song_done,
        input  note_done
    );

    modport slave (
        input  rom_addr,
        output rom_dout,
        input  note,
        input  duration,
        input  new_note,
        input  song_done,
        output note_done
    );
endinterface

// File: rtl/song_reader.sv
// Walks one song of the ROM entry by entry and hands each {note, duration}
// to the note player with a single-cycle load strobe.
module song_reader #(
    parameter int NOTE_IDX_W = 5,
    parameter int SONG_W     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [SONG_W-1:0] song,
    song_reader_if.master     bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_WAIT  = 3'd3,
        S_END   = 3'd4
    } state_t;

    localparam logic [NOTE_IDX_W-1:0] IDX_ZERO = {NOTE_IDX_W{1'b0}};
    localparam logic [NOTE_IDX_W-1:0] IDX_ONE  = {{(NOTE_IDX_W-1){1'b0}}, 1'b1};
    localparam logic [NOTE_IDX_W-1:0] IDX_MAX  = {NOTE_IDX_W{1'b1}};

    state_t                  state_q, state_d;
    logic [NOTE_IDX_W-1:0]   note_idx_q, note_idx_d;
    logic [SONG_W-1:0]       song_q, song_d;
    logic [5:0]              note_q, note_d;
    logic [5:0]              duration_q, duration_d;
    logic                    new_note_q, new_note_d;
    logic                    song_done_q, song_done_d;
    logic                    song_changed_s;

    // Next-state, entry index and output register inputs.
    always_comb begin
        state_d        = state_q;
        note_idx_d     = note_idx_q;
        note_d         = note_q;
        duration_d     = duration_q;
        song_d         = song;
        song_changed_s = (song != song_q);

        if (song_changed_s && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            note_idx_d = IDX_ZERO;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (play) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FETCH: state_d = S_LOAD;
                // A zero duration marks the end of the song and is never loaded.
                S_LOAD: begin
                    if (bus.rom_dout[5:0] == 6'd0) begin
                        state_d = S_END;
                    end else begin
                        state_d    = S_WAIT;
                        note_d     = bus.rom_dout[11:6];
                        duration_d = bus.rom_dout[5:0];
                    end
                end
                // new_note_q marks the first WAIT cycle, where note_done may be stale.
                S_WAIT: begin
                    if (!new_note_q && play && bus.note_done) begin
                        if (note_idx_q == IDX_MAX) begin
                            state_d = S_END;
                        end else begin
                            state_d    = S_FETCH;
                            note_idx_d = note_idx_q + IDX_ONE;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_END: begin
                    if (!play) begin
                        state_d    = S_IDLE;
                        note_idx_d = IDX_ZERO;
                    end else begin
                        state_d = S_END;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    note_idx_d = IDX_ZERO;
                end
            endcase
        end

        new_note_d  = (state_q == S_LOAD) && (state_d == S_WAIT);
        song_done_d = (state_d == S_END);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            note_idx_q  <= IDX_ZERO;
            song_q      <= {SONG_W{1'b0}};
            note_q      <= 6'd0;
            duration_q  <= 6'd0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            note_idx_q  <= note_idx_d;
            song_q      <= song_d;
            note_q      <= note_d;
            duration_q  <= duration_d;
            new_note_q  <= new_note_d;
            song_done_q <= song_done_d;
        end
    end

    assign bus.rom_addr  = {song, note_idx_q};
    assign bus.note      = note_q;
    assign bus.duration  = duration_q;
    assign bus.new_note  = new_note_q;
    assign bus.song_done = song_done_q;
endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader: an event-level playback model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_song_reader;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       play = 1'b0;
    logic [1:0] song = 2'd0;

    song_reader_if #(.NOTE_IDX_W(5), .SONG_W(2)) bus ();

    song_reader #(.NOTE_IDX_W(5), .SONG_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .play  (play),
        .song  (song),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [11:0] rom [0:127];
    always @(posedge clk) bus.rom_dout <= rom[bus.rom_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Playback model: entry index, pending fetch delay, and player-facing outputs.
    int         m_idx = 0;
    int         m_lead = 0;
    int         m_since = 0;
    int         m_song_q = 0;
    bit         m_playing = 1'b0;
    bit         m_done = 1'b0;
    bit         m_new = 1'b0;
    logic [5:0] m_note = 6'd0;
    logic [5:0] m_dur = 6'd0;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_idx = 0; m_lead = 0; m_since = 0; m_song_q = 0;
            m_playing = 1'b0; m_done = 1'b0; m_new = 1'b0;
            m_note = 6'd0; m_dur = 6'd0;
        end else begin
            bit   busy;
            bit   chg;
            logic [11:0] w;
            busy = (m_lead > 0) || m_playing || m_done;
            chg  = (int'(song) != m_song_q) && busy;
            m_song_q = int'(song);
            m_new = 1'b0;
            if (chg) begin
                m_idx = 0; m_lead = 0; m_playing = 1'b0; m_done = 1'b0;
            end else if (m_lead > 0) begin
                m_lead--;
                if (m_lead == 0) begin
                    w = rom[int'(song) * 32 + m_idx];
                    if (w[5:0] == 6'd0) begin
                        m_done = 1'b1;
                    end else begin
                        m_new = 1'b1; m_note = w[11:6]; m_dur = w[5:0];
                        m_playing = 1'b1; m_since = 0;
                    end
                end
            end else if (m_playing) begin
                if (m_since >= 1 && play && bus.note_done) begin
                    m_playing = 1'b0;
                    if (m_idx == 31) m_done = 1'b1;
                    else begin m_idx++; m_lead = 2; end
                end else begin
                    m_since++;
                end
            end else if (m_done) begin
                if (!play) begin m_done = 1'b0; m_idx = 0; end
            end else if (play) begin
                m_lead = 2;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("cmp_new_note",  32'(bus.new_note),  32'(m_new));
        check("cmp_note",      32'(bus.note),      32'(m_note));
        check("cmp_duration",  32'(bus.duration),  32'(m_dur));
        check("cmp_song_done", 32'(bus.song_done), 32'(m_done));
        check("cmp_rom_addr",  32'(bus.rom_addr),  32'(int'(song) * 32 + m_idx));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        for (int i = 0; i < 128; i++) rom[i] = 12'd0;
        rom[0] = {6'd10, 6'd3};
        rom[1] = {6'd12, 6'd5};
        for (int i = 0; i < 32; i++) rom[32 + i] = {6'(i + 1), 6'((i % 7) + 1)};
        rom[64] = {6'd33, 6'd9};
        rom[65] = {6'd34, 6'd2};
        bus.note_done = 1'b0;

        // Reset state
        tick(3);
        check("rst_new_note",  32'(bus.new_note),  32'd0);
        check("rst_note",      32'(bus.note),      32'd0);
        check("rst_duration",  32'(bus.duration),  32'd0);
        check("rst_song_done", 32'(bus.song_done), 32'd0);
        check("rst_rom_addr",  32'(bus.rom_addr),  32'd0);
        reset = 1'b1;

        // Basic fetch on song 0
        play = 1'b1;
        tick(3);
        check("basic_strobe0", 32'(bus.new_note), 32'd1);
        check("basic_note0",   32'(bus.note),     32'd10);
        check("basic_dur0",    32'(bus.duration), 32'd3);
        tick(1);
        check("basic_strobe_off", 32'(bus.new_note), 32'd0);
        bus.note_done = 1'b1; tick(1); bus.note_done = 1'b0; tick(2);
        check("basic_strobe1", 32'(bus.new_note), 32'd1);
        check("basic_note1",   32'(bus.note),     32'd12);
        check("basic_dur1",    32'(bus.duration), 32'd5);
        tick(1);
        bus.note_done = 1'b1; tick(1); bus.note_done = 1'b0; tick(2);
        check("basic_done",      32'(bus.song_done), 32'd1);
        check("basic_no_strobe", 32'(bus.new_note),  32'd0);
        check("basic_note_held", 32'(bus.note),      32'd12);
        tick(5);
        check("basic_done_held", 32'(bus.song_done), 32'd1);
        play = 1'b0;
        tick(1);
        check("basic_idle_done", 32'(bus.song_done), 32'd0);

        // Full song 1 with note_done forced high
        song = 2'd1; bus.note_done = 1'b1; play = 1'b1;
        k = 0;
        for (int c = 0; c < 300 && !bus.song_done; c++) begin
            tick(1);
            if (bus.new_note) begin
                check("full_note", 32'(bus.note),     32'(k + 1));
                check("full_dur",  32'(bus.duration), 32'((k % 7) + 1));
                k++;
            end
        end
        check("full_strobes",   32'(k),             32'd32);
        check("full_song_done", 32'(bus.song_done), 32'd1);
        check("full_model_idx", 32'(m_idx),         32'd31);
        play = 1'b0; bus.note_done = 1'b0;
        tick(1);

        // Pause in WAIT with note_done high
        play = 1'b1;
        tick(3);
        check("pause_first_note", 32'(bus.note), 32'd1);
        tick(1);
        play = 1'b0; bus.note_done = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            check("pause_no_strobe", 32'(bus.new_note), 32'd0);
            check("pause_addr",      32'(bus.rom_addr), 32'd32);
        end
        play = 1'b1;
        tick(3);
        check("pause_resume_strobe", 32'(bus.new_note), 32'd1);
        check("pause_resume_note",   32'(bus.note),     32'd2);

        // Stale done held through the first WAIT cycle
        tick(1);
        check("stale_no_strobe", 32'(bus.new_note), 32'd0);
        check("stale_addr",      32'(bus.rom_addr), 32'd33);
        tick(3);
        check("stale_strobe", 32'(bus.new_note), 32'd1);
        check("stale_note",   32'(bus.note),     32'd3);
        bus.note_done = 1'b0;

        // Song switch mid-note
        song = 2'd0;
        tick(4);
        check("switch0_note", 32'(bus.note), 32'd10);
        tick(1);
        song = 2'd2;
        tick(1);
        check("switch_addr",      32'(bus.rom_addr),  32'd64);
        check("switch_no_strobe", 32'(bus.new_note),  32'd0);
        check("switch_not_done",  32'(bus.song_done), 32'd0);
        tick(3);
        check("switch_strobe", 32'(bus.new_note), 32'd1);
        check("switch_note",   32'(bus.note),     32'd33);
        check("switch_dur",    32'(bus.duration), 32'd9);

        // Asynchronous reset between clock edges
        tick(1);
        #2 reset = 1'b0;
        #1;
        check("arst_note",      32'(bus.note),      32'd0);
        check("arst_duration",  32'(bus.duration),  32'd0);
        check("arst_new_note",  32'(bus.new_note),  32'd0);
        check("arst_song_done", 32'(bus.song_done), 32'd0);
        check("arst_rom_addr",  32'(bus.rom_addr),  32'd64);
        @(posedge clk); #1;
        reset = 1'b1;
        tick(3);
        check("arst_strobe", 32'(bus.new_note), 32'd1);
        check("arst_note0",  32'(bus.note),     32'd33);
        tick(1);
        bus.note_done = 1'b1;
        tick(3);
        check("arst_note1", 32'(bus.note), 32'd34);
        tick(4);
        check("arst_end", 32'(bus.song_done), 32'd1);
        bus.note_done = 1'b0; play = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
